demux1_2_buf: RTL and testbench



---
 rtl/demux1_2_buf.sv | 108 ++++++++++
 tb/tb_demux1_2_buf.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux1_2_buf.sv
// demux1_2_buf: 1-to-2 valid/ready demux, 2-entry FIFO per output.
// Define DEMUX1_2_CNT_EN to add ACNT/BCNT output-transfer counters.
module demux1_2_buf #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic [0:W-1] I,
  input  logic         S,
  input  logic         IV,
  output logic         IR,
  output logic [0:W-1] A,
  output logic         AV,
  input  logic         AR,
  output logic [0:W-1] B,
  output logic         BV,
  input  logic         BR
`ifdef DEMUX1_2_CNT_EN
  ,
  output logic [0:15]  ACNT,
  output logic [0:15]  BCNT
`endif
);

  localparam int DEPTH = 2;

  logic [0:W-1] mem_a [DEPTH];
  logic [0:W-1] mem_b [DEPTH];
  logic [1:0]   cnt_a;
  logic [1:0]   cnt_b;
  logic         rd_a;
  logic         wr_a;
  logic         rd_b;
  logic         wr_b;
  logic         push_a;
  logic         push_b;
  logic         pop_a;
  logic         pop_b;

  // Ready depends only on S and the counts, never on AR/BR.
  assign IR = S ? (cnt_a < 2'd2) : (cnt_b < 2'd2);

  assign push_a = IV && IR && S;
  assign push_b = IV && IR && !S;
  assign pop_a  = AV && AR;
  assign pop_b  = BV && BR;

  assign AV = (cnt_a != 2'd0);
  assign BV = (cnt_b != 2'd0);
  assign A  = mem_a[rd_a];
  assign B  = mem_b[rd_b];

  // FIFO A: storage, pointers and occupancy.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int k = 0; k < DEPTH; k++) mem_a[k] <= '0;
      rd_a  <= 1'b0;
      wr_a  <= 1'b0;
      cnt_a <= 2'd0;
    end else begin
      if (push_a) begin
        mem_a[wr_a] <= I;
        wr_a        <= ~wr_a;
      end
      if (pop_a) rd_a <= ~rd_a;
      unique case ({push_a, pop_a})
        2'b10:   cnt_a <= cnt_a + 2'd1;
        2'b01:   cnt_a <= cnt_a - 2'd1;
        default: cnt_a <= cnt_a;
      endcase
    end
  end

  // FIFO B: storage, pointers and occupancy.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int k = 0; k < DEPTH; k++) mem_b[k] <= '0;
      rd_b  <= 1'b0;
      wr_b  <= 1'b0;
      cnt_b <= 2'd0;
    end else begin
      if (push_b) begin
        mem_b[wr_b] <= I;
        wr_b        <= ~wr_b;
      end
      if (pop_b) rd_b <= ~rd_b;
      unique case ({push_b, pop_b})
        2'b10:   cnt_b <= cnt_b + 2'd1;
        2'b01:   cnt_b <= cnt_b - 2'd1;
        default: cnt_b <= cnt_b;
      endcase
    end
  end

`ifdef DEMUX1_2_CNT_EN
  // Completed output transfers per side, wrapping at 16 bits.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ACNT <= '0;
      BCNT <= '0;
    end else begin
      if (pop_a) ACNT <= ACNT + 16'd1;
      if (pop_b) BCNT <= BCNT + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_demux1_2_buf.sv
// tb_demux1_2_buf: scoreboard bench for demux1_2_buf.
// Define DEMUX1_2_CNT_EN to also exercise ACNT/BCNT.
module tb_demux1_2_buf;

  logic        CLK;
  logic        RST_N;
  logic [0:31] I;
  logic        S;
  logic        IV;
  logic        IR;
  logic [0:31] A;
  logic        AV;
  logic        AR;
  logic [0:31] B;
  logic        BV;
  logic        BR;
`ifdef DEMUX1_2_CNT_EN
  logic [0:15] ACNT;
  logic [0:15] BCNT;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int pops_a  = 0;
  int pops_b  = 0;
  logic [0:31] qa [$];
  logic [0:31] qb [$];

  demux1_2_buf #(.W(32)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .I(I), .S(S), .IV(IV), .IR(IR),
    .A(A), .AV(AV), .AR(AR),
    .B(B), .BV(BV), .BR(BR)
`ifdef DEMUX1_2_CNT_EN
    , .ACNT(ACNT), .BCNT(BCNT)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Scoreboard: every output transfer must match the oldest pushed word.
  always @(negedge CLK) begin
    logic [0:31] e;
    if (RST_N && AV && AR) begin
      n_tests++;
      pops_a++;
      if (qa.size() == 0) begin
        n_fail++;
        $display("FAIL a_pop: got %h, expected no word", A);
      end else begin
        e = qa.pop_front();
        if (A !== e) begin
          n_fail++;
          $display("FAIL a_pop: got %h, expected %h", A, e);
        end
      end
    end
    if (RST_N && BV && BR) begin
      n_tests++;
      pops_b++;
      if (qb.size() == 0) begin
        n_fail++;
        $display("FAIL b_pop: got %h, expected no word", B);
      end else begin
        e = qb.pop_front();
        if (B !== e) begin
          n_fail++;
          $display("FAIL b_pop: got %h, expected %h", B, e);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic cyc(input logic iv, input logic s, input logic [0:31] d,
                     input logic ar, input logic br);
    @(posedge CLK);
    #1;
    IV = iv; S = s; I = d; AR = ar; BR = br;
    @(negedge CLK);
    if (IV && IR) begin
      if (S) qa.push_back(I);
      else   qb.push_back(I);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    #2 RST_N = 1'b0;
    IV = 1'b0; AR = 1'b0; BR = 1'b0;
    qa.delete();
    qb.delete();
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    n_tests++;
    if ({IR, AV, BV} !== 3'b100 || A !== 32'h0 || B !== 32'h0) begin
      n_fail++;
      $display("FAIL init_state: IR/AV/BV=%b A=%h B=%h, expected 100 0 0",
               {IR, AV, BV}, A, B);
    end
    cyc(1, 1, 32'h11110001, 0, 0);
    cyc(1, 1, 32'h11110002, 0, 0);
    cyc(1, 0, 32'h22220001, 0, 0);
    cyc(1, 0, 32'h22220002, 0, 0);
    cyc(0, 1, 32'h0, 0, 0);
    n_tests++;
    if ({IR, AV, BV} !== 3'b011) begin
      n_fail++;
      $display("FAIL full_before_reset: IR/AV/BV=%b, expected 011",
               {IR, AV, BV});
    end
    #2 RST_N = 1'b0;
    #1;
    n_tests++;
    if ({IR, AV, BV} !== 3'b100 || A !== 32'h0 || B !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset: IR/AV/BV=%b A=%h B=%h, expected 100 0 0",
               {IR, AV, BV}, A, B);
    end
`ifdef DEMUX1_2_CNT_EN
    n_tests++;
    if (ACNT !== 16'h0 || BCNT !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_cnt: ACNT=%h BCNT=%h, expected 0 0", ACNT, BCNT);
    end
`endif
    qa.delete();
    qb.delete();
    IV = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_steering();
    cyc(1, 1, 32'h12345678, 1, 1);
    cyc(1, 0, 32'hCAFEF00D, 1, 1);
    n_tests++;
    if (AV !== 1'b1 || A !== 32'h12345678 || BV !== 1'b0) begin
      n_fail++;
      $display("FAIL steer_a: AV=%b A=%h BV=%b, expected 1 12345678 0",
               AV, A, BV);
    end
    cyc(0, 0, 32'h0, 1, 1);
    n_tests++;
    if (BV !== 1'b1 || B !== 32'hCAFEF00D || AV !== 1'b0) begin
      n_fail++;
      $display("FAIL steer_b: BV=%b B=%h AV=%b, expected 1 cafef00d 0",
               BV, B, AV);
    end
    cyc(0, 0, 32'h0, 1, 1);
  endtask

  task automatic test_stall();
    cyc(1, 1, 32'hA0000001, 0, 1);
    cyc(1, 1, 32'hA0000002, 0, 1);
    cyc(1, 1, 32'hA0000003, 0, 1);
    n_tests++;
    if (IR !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_ir_a: IR=%b, expected 0", IR);
    end
    cyc(1, 0, 32'hB0000001, 0, 1);
    n_tests++;
    if (IR !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_ir_b: IR=%b, expected 1", IR);
    end
    cyc(0, 0, 32'h0, 0, 1);
    n_tests++;
    if (BV !== 1'b1 || B !== 32'hB0000001) begin
      n_fail++;
      $display("FAIL stall_b: BV=%b B=%h, expected 1 b0000001", BV, B);
    end
    cyc(0, 0, 32'h0, 1, 1);
    n_tests++;
    if (AV !== 1'b1 || A !== 32'hA0000001) begin
      n_fail++;
      $display("FAIL stall_a1: AV=%b A=%h, expected 1 a0000001", AV, A);
    end
    cyc(0, 0, 32'h0, 1, 1);
    n_tests++;
    if (AV !== 1'b1 || A !== 32'hA0000002) begin
      n_fail++;
      $display("FAIL stall_a2: AV=%b A=%h, expected 1 a0000002", AV, A);
    end
    cyc(0, 0, 32'h0, 1, 1);
    n_tests++;
    if (AV !== 1'b0 || BV !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_drain: AV=%b BV=%b, expected 0 0", AV, BV);
    end
  endtask

  task automatic test_full_pop();
    cyc(1, 1, 32'hF0000001, 0, 0);
    cyc(1, 1, 32'hF0000002, 0, 0);
    cyc(1, 1, 32'hF0000003, 1, 0);
    n_tests++;
    if (IR !== 1'b0) begin
      n_fail++;
      $display("FAIL full_pop_ir0: IR=%b, expected 0", IR);
    end
    cyc(1, 1, 32'hF0000003, 1, 0);
    n_tests++;
    if (IR !== 1'b1) begin
      n_fail++;
      $display("FAIL full_pop_ir1: IR=%b, expected 1", IR);
    end
    cyc(0, 1, 32'h0, 1, 0);
    cyc(0, 1, 32'h0, 1, 0);
    cyc(0, 1, 32'h0, 1, 0);
    n_tests++;
    if (qa.size() != 0 || AV !== 1'b0) begin
      n_fail++;
      $display("FAIL full_pop_drain: left=%0d AV=%b, expected 0 0",
               qa.size(), AV);
    end
  endtask

  task automatic test_streaming();
    logic        ps;
    logic [0:31] pw;
    int          base;
    base = pops_a + pops_b;
    ps = 1'b0;
    pw = '0;
    for (int k = 0; k < 100; k++) begin
      logic [0:31] w;
      w = $urandom;
      cyc(1, k[0], w, 1, 1);
      n_tests++;
      if (IR !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_ir: word %0d IR=%b, expected 1", k, IR);
      end
      if (k > 0) begin
        n_tests++;
        if (ps ? (AV !== 1'b1 || A !== pw) : (BV !== 1'b1 || B !== pw)) begin
          n_fail++;
          $display("FAIL stream_out: word %0d AV=%b A=%h BV=%b B=%h, want %h",
                   k - 1, AV, A, BV, B, pw);
        end
      end
      ps = k[0];
      pw = w;
    end
    cyc(0, 0, 32'h0, 1, 1);
    cyc(0, 0, 32'h0, 1, 1);
    n_tests++;
    if (pops_a + pops_b - base != 100 || qa.size() + qb.size() != 0) begin
      n_fail++;
      $display("FAIL stream_count: delivered %0d left %0d, expected 100 0",
               pops_a + pops_b - base, qa.size() + qb.size());
    end
  endtask

`ifdef DEMUX1_2_CNT_EN
  task automatic test_counters();
    do_reset();
    for (int k = 0; k < 65537; k++) cyc(1, 1, k, 1, 1);
    cyc(0, 0, 32'h0, 1, 1);
    cyc(0, 0, 32'h0, 1, 1);
    n_tests++;
    if (ACNT !== 16'h0001 || BCNT !== 16'h0000) begin
      n_fail++;
      $display("FAIL cnt_wrap: ACNT=%h BCNT=%h, expected 0001 0000",
               ACNT, BCNT);
    end
  endtask
`endif

  initial begin
    RST_N = 1'b0;
    IV = 1'b0; S = 1'b0; I = '0; AR = 1'b0; BR = 1'b0;
    repeat (2) @(posedge CLK);
    #2 RST_N = 1'b1;
    test_reset();
    test_steering();
    test_stall();
    test_full_pop();
    test_streaming();
    do_reset();
    test_steering();
`ifdef DEMUX1_2_CNT_EN
    test_counters();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
